// File: rtl/keypad_digit_entry.sv
`default_nettype none
// ============================================================================
// Module      : keypad_digit_entry
// Description : 3x4 keypad scanner with debounce, key encoding and a
//               two-digit BCD shift register feeding the display path.
// Revision    : 1.0 - initial release
// ============================================================================
module keypad_digit_entry #(
    parameter int SCAN_DIV  = 12500,
    parameter int DEB_TICKS = 4
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic [3:0] KEY_ROW,
    output logic [2:0] KEY_COL,
    output logic       KEY_VALID,
    output logic [3:0] KEY_CODE,
    output logic [3:0] DIGIT1,
    output logic [3:0] DIGIT2
);

    localparam int c_div_w = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int c_cnt_w = $clog2(DEB_TICKS + 1);
    localparam logic [c_div_w-1:0] c_div_last = c_div_w'(SCAN_DIV - 1);
    localparam logic [c_cnt_w-1:0] c_deb_max  = c_cnt_w'(DEB_TICKS);

    typedef enum logic [2:0] {
        ST_IDLE = 3'b000,
        ST_COL1 = 3'b001,
        ST_COL2 = 3'b010,
        ST_COL3 = 3'b100
    } state_t;

    logic [c_div_w-1:0] r_div_cnt;
    logic               w_tick;
    state_t             r_state;
    logic               r_prev_valid;
    logic [3:0]         r_prev_code;
    logic [c_cnt_w-1:0] r_stable_cnt;
    logic [c_cnt_w-1:0] r_rel_cnt;
    logic               r_reported;
    logic               r_key_valid;
    logic [3:0]         r_key_code;
    logic [3:0]         r_digit1;
    logic [3:0]         r_digit2;

    logic               w_raw_valid;
    logic [3:0]         w_raw_code;
    logic [c_cnt_w-1:0] w_stable_next;
    logic [c_cnt_w-1:0] w_rel_next;
    logic               w_accept;

    assign w_tick = (r_div_cnt == c_div_last);

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_div_cnt <= '0;
        end else if (w_tick) begin
            r_div_cnt <= '0;
        end else begin
            r_div_cnt <= r_div_cnt + 1'b1;
        end
    end

    // Keypad layout: each column maps its four rows top to bottom.
    always_comb begin
        w_raw_code = 4'd0;
        case (r_state)
            ST_COL1: begin
                case (KEY_ROW)
                    4'b0001: w_raw_code = 4'd1;
                    4'b0010: w_raw_code = 4'd4;
                    4'b0100: w_raw_code = 4'd7;
                    4'b1000: w_raw_code = 4'd10;
                    default: w_raw_code = 4'd0;
                endcase
            end
            ST_COL2: begin
                case (KEY_ROW)
                    4'b0001: w_raw_code = 4'd2;
                    4'b0010: w_raw_code = 4'd5;
                    4'b0100: w_raw_code = 4'd8;
                    4'b1000: w_raw_code = 4'd0;
                    default: w_raw_code = 4'd0;
                endcase
            end
            ST_COL3: begin
                case (KEY_ROW)
                    4'b0001: w_raw_code = 4'd3;
                    4'b0010: w_raw_code = 4'd6;
                    4'b0100: w_raw_code = 4'd9;
                    4'b1000: w_raw_code = 4'd11;
                    default: w_raw_code = 4'd0;
                endcase
            end
            default: w_raw_code = 4'd0;
        endcase
    end

    assign w_raw_valid = $onehot(KEY_ROW) && (r_state != ST_IDLE);

    always_comb begin
        w_stable_next = '0;
        w_rel_next    = '0;
        if (w_raw_valid) begin
            if (r_prev_valid && (r_prev_code == w_raw_code)) begin
                w_stable_next = (r_stable_cnt == c_deb_max) ? c_deb_max
                                                            : r_stable_cnt + 1'b1;
            end else begin
                w_stable_next = c_cnt_w'(1);
            end
        end else begin
            w_rel_next = (r_rel_cnt == c_deb_max) ? c_deb_max : r_rel_cnt + 1'b1;
        end
    end

    assign w_accept = w_raw_valid && (w_stable_next == c_deb_max) && !r_reported;

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_state      <= ST_IDLE;
            r_prev_valid <= 1'b0;
            r_prev_code  <= 4'd0;
            r_stable_cnt <= '0;
            r_rel_cnt    <= '0;
            r_reported   <= 1'b0;
            r_key_valid  <= 1'b0;
            r_key_code   <= 4'd0;
        end else begin
            r_key_valid <= 1'b0;
            if (w_tick) begin
                // Any active row locks the column so the debouncer sees one key.
                case (r_state)
                    ST_IDLE: r_state <= ST_COL1;
                    ST_COL1: if (KEY_ROW == 4'b0000) r_state <= ST_COL2;
                    ST_COL2: if (KEY_ROW == 4'b0000) r_state <= ST_COL3;
                    ST_COL3: if (KEY_ROW == 4'b0000) r_state <= ST_COL1;
                    default: r_state <= ST_IDLE;
                endcase
                r_prev_valid <= w_raw_valid;
                r_prev_code  <= w_raw_code;
                r_stable_cnt <= w_stable_next;
                r_rel_cnt    <= w_rel_next;
                if (w_accept) begin
                    r_key_valid <= 1'b1;
                    r_key_code  <= w_raw_code;
                    r_reported  <= 1'b1;
                end else if (!w_raw_valid && (w_rel_next == c_deb_max)) begin
                    r_reported  <= 1'b0;
                end
            end
        end
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_digit1 <= 4'd0;
            r_digit2 <= 4'd0;
        end else if (r_key_valid) begin
            if (r_key_code <= 4'd9) begin
                r_digit1 <= r_digit2;
                r_digit2 <= r_key_code;
            end else if (r_key_code == 4'd10) begin
                r_digit1 <= 4'd0;
                r_digit2 <= 4'd0;
            end
        end
    end

    assign KEY_COL   = r_state;
    assign KEY_VALID = r_key_valid;
    assign KEY_CODE  = r_key_code;
    assign DIGIT1    = r_digit1;
    assign DIGIT2    = r_digit2;

endmodule
`default_nettype wire

// File: tb/tb_keypad_digit_entry.sv
`default_nettype none
// ============================================================================
// Module      : tb_keypad_digit_entry
// Description : Scoreboard bench for keypad_digit_entry with a keypad model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_keypad_digit_entry;

    localparam int SCAN_DIV  = 4;
    localparam int DEB_TICKS = 3;

    typedef struct packed {
        logic [3:0] code;
        logic [3:0] d1;
        logic [3:0] d2;
    } exp_t;

    logic       CLK = 1'b0;
    logic       RESET = 1'b1;
    logic [3:0] KEY_ROW;
    logic [2:0] KEY_COL;
    logic       KEY_VALID;
    logic [3:0] KEY_CODE;
    logic [3:0] DIGIT1;
    logic [3:0] DIGIT2;

    logic [3:0] col_rows [3];
    logic [2:0] col_seq  [4] = '{3'b001, 3'b010, 3'b100, 3'b001};
    exp_t       sb_q [$];
    exp_t       mon_e;
    int         checks = 0;
    int         errors = 0;
    int         cyc = 0;

    keypad_digit_entry #(
        .SCAN_DIV (SCAN_DIV),
        .DEB_TICKS(DEB_TICKS)
    ) dut (
        .CLK      (CLK),
        .RESET    (RESET),
        .KEY_ROW  (KEY_ROW),
        .KEY_COL  (KEY_COL),
        .KEY_VALID(KEY_VALID),
        .KEY_CODE (KEY_CODE),
        .DIGIT1   (DIGIT1),
        .DIGIT2   (DIGIT2)
    );

    always #5 CLK = ~CLK;

    // Keypad matrix: a pressed switch connects its row to the driven column.
    always_comb begin
        KEY_ROW = (KEY_COL[0] ? col_rows[0] : 4'b0000) |
                  (KEY_COL[1] ? col_rows[1] : 4'b0000) |
                  (KEY_COL[2] ? col_rows[2] : 4'b0000);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic clk1();
        @(posedge CLK);
        cyc++;
        #1;
    endtask

    task automatic wait_tick();
        do clk1(); while ((cyc % SCAN_DIV) != 0);
    endtask

    task automatic wait_col1();
        int n = 0;
        while (KEY_COL != 3'b001 && n < 8) begin
            wait_tick();
            n++;
        end
        check("align_col1", KEY_COL, 3'b001);
    endtask

    task automatic key_tap(input int col, input logic [3:0] rows, input exp_t e);
        sb_q.push_back(e);
        col_rows[col] = rows;
        repeat (8) wait_tick();
        col_rows[col] = 4'b0000;
        repeat (4) wait_tick();
    endtask

    // Monitor: every accepted key is matched against the queue, digits one CLK later.
    initial begin
        forever begin
            @(negedge CLK);
            if (!RESET && KEY_VALID === 1'b1) begin
                if (sb_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_key_valid: got KEY_CODE=%0d expected no pulse", KEY_CODE);
                end else begin
                    mon_e = sb_q.pop_front();
                    check("key_code", KEY_CODE, mon_e.code);
                    @(negedge CLK);
                    check("digit1", DIGIT1, mon_e.d1);
                    check("digit2", DIGIT2, mon_e.d2);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no finish expected finish before limit");
        $fatal(1, "timeout");
    end

    initial begin
        logic [2:0] prev_col;
        for (int i = 0; i < 3; i++) col_rows[i] = 4'b0000;
        repeat (3) @(posedge CLK);
        @(negedge CLK);
        check("rst_col", KEY_COL, 3'b000);
        check("rst_valid", KEY_VALID, 1'b0);
        check("rst_code", KEY_CODE, 4'd0);
        check("rst_d1", DIGIT1, 4'd0);
        check("rst_d2", DIGIT2, 4'd0);
        RESET = 1'b0;
        cyc = 0;

        // Idle scan: column steps every SCAN_DIV clocks.
        prev_col = 3'b000;
        for (int i = 0; i < 4; i++) begin
            repeat (SCAN_DIV - 1) clk1();
            check("col_hold", KEY_COL, prev_col);
            clk1();
            check("col_step", KEY_COL, col_seq[i]);
            prev_col = col_seq[i];
        end
        check("idle_no_valid", KEY_VALID, 1'b0);

        // Key 5 held: lock at COL2, accept on the third sample.
        sb_q.push_back('{4'd5, 4'd0, 4'd5});
        col_rows[1] = 4'b0010;
        wait_tick();
        check("k5_reach_col2", KEY_COL, 3'b010);
        wait_tick();
        check("k5_lock_col2", KEY_COL, 3'b010);
        wait_tick();
        check("k5_no_early_valid", KEY_VALID, 1'b0);
        wait_tick();
        check("k5_valid_3rd", KEY_VALID, 1'b1);
        check("k5_code", KEY_CODE, 4'd5);
        repeat (2) wait_tick();
        col_rows[1] = 4'b0000;
        repeat (4) wait_tick();

        key_tap(0, 4'b0010, '{4'd4, 4'd5, 4'd4});
        key_tap(1, 4'b0001, '{4'd2, 4'd4, 4'd2});
        key_tap(2, 4'b0100, '{4'd9, 4'd2, 4'd9});

        // Bouncing 7: the chatter sample shorts two rows, which is invalid.
        wait_col1();
        sb_q.push_back('{4'd7, 4'd9, 4'd7});
        col_rows[0] = 4'b0100;
        wait_tick();
        col_rows[0] = 4'b1100;
        wait_tick();
        col_rows[0] = 4'b0100;
        repeat (2) wait_tick();
        check("bounce_no_early", KEY_VALID, 1'b0);
        wait_tick();
        check("bounce_valid_5th", KEY_VALID, 1'b1);
        check("bounce_code", KEY_CODE, 4'd7);
        repeat (2) wait_tick();
        col_rows[0] = 4'b0000;
        repeat (4) wait_tick();

        key_tap(0, 4'b1000, '{4'd10, 4'd0, 4'd0});
        key_tap(2, 4'b1000, '{4'd11, 4'd0, 4'd0});

        // Two rows held in COL3: no acceptance, column stays locked.
        col_rows[2] = 4'b0011;
        repeat (9) wait_tick();
        check("multi_lock_col3", KEY_COL, 3'b100);
        check("multi_d1", DIGIT1, 4'd0);
        check("multi_d2", DIGIT2, 4'd0);
        col_rows[2] = 4'b0000;
        repeat (4) wait_tick();

        key_tap(2, 4'b0001, '{4'd3, 4'd0, 4'd3});
        key_tap(1, 4'b0100, '{4'd8, 4'd3, 4'd8});
        check("pre_rst_d1", DIGIT1, 4'd3);
        check("pre_rst_d2", DIGIT2, 4'd8);

        // Reset mid-debounce with key 1 held.
        wait_col1();
        col_rows[0] = 4'b0001;
        repeat (2) wait_tick();
        clk1();
        RESET = 1'b1;
        #1;
        check("mid_rst_col", KEY_COL, 3'b000);
        check("mid_rst_valid", KEY_VALID, 1'b0);
        check("mid_rst_code", KEY_CODE, 4'd0);
        check("mid_rst_d1", DIGIT1, 4'd0);
        check("mid_rst_d2", DIGIT2, 4'd0);
        @(posedge CLK);
        @(negedge CLK);
        RESET = 1'b0;
        cyc = 0;
        sb_q.push_back('{4'd1, 4'd0, 4'd1});
        wait_tick();
        check("post_rst_col1", KEY_COL, 3'b001);
        repeat (2) wait_tick();
        check("post_rst_no_early", KEY_VALID, 1'b0);
        wait_tick();
        check("post_rst_valid", KEY_VALID, 1'b1);
        check("post_rst_code", KEY_CODE, 4'd1);
        col_rows[0] = 4'b0000;
        repeat (4) wait_tick();

        check("scoreboard_empty", sb_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/keypad_digit_entry.md
Name: keypad_digit_entry

Overview:
- Input-side counterpart of the two-digit 7-segment display path.
- Scans a 3-column x 4-row keypad and debounces presses.
- Encodes each press to a 4-bit code and shifts decimal keys into a two-digit BCD register.
- DIGIT1/DIGIT2 connect directly to the display block's two digit inputs (left and right digit).

Parameters:
SCAN_DIV, 12500, CLK cycles per scan tick (12500 at 25 MHz gives a 2 kHz tick)
DEB_TICKS, 4, consecutive identical valid samples required to accept a key; also consecutive empty samples required to accept release

Ports:
CLK  input  1  system clock
RESET  input  1  asynchronous, active-high reset
KEY_ROW  input  4  keypad row sense, active-high, bit0 = top row
KEY_COL  output  3  one-hot column drive, 000 when idle
KEY_VALID  output  1  one-CLK pulse when a debounced press is accepted
KEY_CODE  output  4  code of last accepted key: 0-9 digits, 10 = '*', 11 = '#'
DIGIT1  output  4  left display digit, BCD
DIGIT2  output  4  right display digit, BCD

Behaviour:
- Reset: RESET is asynchronous, active-high; clock is CLK. Reset clears all counters. KEY_COL=000, KEY_VALID=0, KEY_CODE=0, DIGIT1=0, DIGIT2=0, debounce state cleared. Assertion mid-scan or mid-debounce aborts immediately.
- Tick generator:
  - Counter runs 0..SCAN_DIV-1 and wraps.
  - TICK is high for one CLK when counter = SCAN_DIV-1.
  - All FSM and debounce updates occur only on TICK cycles.
- Scan FSM: states IDLE(000), COL1(001), COL2(010), COL3(100); KEY_COL = state encoding.
  - IDLE -> COL1 on first TICK.
  - If KEY_ROW = 0000 on TICK: COL1 -> COL2 -> COL3 -> COL1.
  - If any KEY_ROW bit is set on TICK: the column holds (lock) until rows read 0000.
- Raw decode (combinational, current column):
  - COL1 rows 0..3 = 1, 4, 7, 10.
  - COL2 rows 0..3 = 2, 5, 8, 0.
  - COL3 rows 0..3 = 3, 6, 9, 11.
  - Raw is valid only if exactly one row bit is set and the state is not IDLE. Multi-row or zero rows are invalid.
- Debounce (on TICK):
  - Registered previous sample = (valid, code).
  - Valid and equal to previous sample: stable count increments, saturating at DEB_TICKS.
  - Valid but different code: count = 1.
  - Invalid: count = 0, release count increments (saturating at DEB_TICKS). Any valid sample clears release count.
  - Accept: on the TICK where the count reaches DEB_TICKS and the reported flag = 0, KEY_VALID = 1 for that CLK. KEY_CODE loads the code on the same edge. The reported flag is then set.
  - Reported flag clears only when release count reaches DEB_TICKS. A held key produces exactly one pulse; no auto-repeat.
  - A different key pressed while reported = 1 is ignored until full release.
- Digit register: updated on the CLK edge after KEY_VALID (one CLK latency).
  - Code 0-9: DIGIT1 <= DIGIT2, DIGIT2 <= code (shift in from right).
  - Code 10 ('*'): DIGIT1 <= 0, DIGIT2 <= 0.
  - Code 11 ('#'): digits unchanged.
- Latency: from the first TICK sampling a stable press to KEY_VALID = DEB_TICKS-1 further ticks; DIGIT update follows one CLK later.
- Outputs DIGIT1/DIGIT2 are always in 0-9; no illegal BCD is ever produced.

Test Plan:
- SCAN_DIV=4, DEB_TICKS=3, no keys held: KEY_COL sequence after reset is 000, 001, 010, 100, 001..., each step 4 CLKs apart. KEY_VALID never asserts.
- Hold row1 while COL2 is driven for 5 ticks, then release: FSM locks at 010. Exactly one KEY_VALID, KEY_CODE=5 on the 3rd consecutive sample. Next CLK: DIGIT1=0, DIGIT2=5.
- Press 4 (COL1 row1), release, then press 2 (COL2 row0): DIGIT1=4, DIGIT2=2. Then press 9: DIGIT1=2, DIGIT2=9.
- Bouncing 7 pattern: valid, invalid, valid, valid, valid on successive ticks -> single KEY_VALID with KEY_CODE=7, raised on the 5th tick. Press '*' afterwards -> DIGIT1=0, DIGIT2=0. Press '#' -> KEY_CODE=11, digits unchanged.
- Hold two rows of COL3 simultaneously for 6 ticks -> no KEY_VALID, digits unchanged.
- Assert RESET for one CLK mid-debounce (count=2) with DIGIT1=3, DIGIT2=8: all outputs 0 immediately. After deassertion the still-held key requires a full DEB_TICKS samples before KEY_VALID.
